// File: rtl/mdu_sched.sv
// EX-stage multiply/divide scheduler: single-cycle multiply, 32-step restoring divide,
// with a stall request to the hazard unit while an operation is in flight.
module mdu_sched #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        res_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(DIV_ITERS);
  localparam logic [1:0]  OP_MULT = 2'b00;
  localparam logic [1:0]  OP_DIV  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d, dvs_q, dvs_d;
  logic [2*XLEN-1:0]  rq_q, rq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic               acc_signed, mul_signed, div_signed;
  logic [XLEN-1:0]    a_abs, b_abs, quo_mag, rem_mag, quo_fix, rem_fix;
  logic [2*XLEN-1:0]  ext_a, ext_b, prod, step;
  logic [XLEN:0]      rem_sh, diff;

  // Operand magnitudes for the divider, taken straight from the issue inputs.
  assign acc_signed = (op_i == OP_DIV);
  assign a_abs      = (acc_signed && a_i[31]) ? -a_i : a_i;
  assign b_abs      = (acc_signed && b_i[31]) ? -b_i : b_i;

  // Low 64 bits of a 64x64 product are correct for both signed and unsigned.
  assign mul_signed = (op_q == OP_MULT);
  assign ext_a      = {{XLEN{mul_signed & a_q[31]}}, a_q};
  assign ext_b      = {{XLEN{mul_signed & b_q[31]}}, b_q};
  assign prod       = ext_a * ext_b;

  // One restoring step: shift {rem,quo}, trial-subtract the 33-bit divisor.
  assign rem_sh = rq_q[2*XLEN-1:XLEN-1];
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign step   = diff[XLEN] ? {rq_q[2*XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};

  assign div_signed = (op_q == OP_DIV);
  assign quo_mag    = rq_q[XLEN-1:0];
  assign rem_mag    = rq_q[2*XLEN-1:XLEN];
  assign quo_fix    = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_mag : quo_mag;
  assign rem_fix    = (div_signed && a_q[31]) ? -rem_mag : rem_mag;

  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_DONE);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dvs_d       = dvs_q;
    rq_d        = rq_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    stall_req_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_req_o = start_i;
        if (start_i) begin
          op_d  = op_i;
          a_d   = a_i;
          b_d   = b_i;
          dvs_d = b_abs;
          rq_d  = {{XLEN{1'b0}}, a_abs};
          cnt_d = '0;
          state_d = op_i[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall_req_o  = 1'b1;
        {hi_d, lo_d} = prod;
        state_d      = S_DONE;
      end
      S_DIV: begin
        stall_req_o = 1'b1;
        rq_d        = step;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        stall_req_o = 1'b1;
        // Divide by zero reports all-ones quotient and the raw dividend.
        if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d     = S_IDLE;
      hi_d        = hi_q;
      lo_d        = lo_q;
      stall_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rq_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvs_q   <= dvs_d;
      rq_q    <= rq_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: directed mult/div vectors, flush and async reset.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_req_o, busy_o, res_valid_o;
  logic [31:0] hi_o, lo_o;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  mdu_sched #(.DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .busy_o(busy_o),
    .res_valid_o(res_valid_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (res_valid_o === 1'b1) begin
      logic [63:0] e;
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%h_%h expected=none", hi_o, lo_o);
      end else begin
        e = exp_q.pop_front();
        if ({hi_o, lo_o} !== e) begin
          errors++;
          $display("FAIL result actual=%h_%h expected=%h_%h", hi_o, lo_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Issue one op, hold start until the result pulse, check latency and stall length.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_cyc);
    int  stl = 0;
    int  cyc = 0;
    bit  got = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    exp_q.push_back(exp);
    #1;
    for (int i = 0; i < 60; i++) begin
      if (res_valid_o === 1'b1) begin
        got = 1; cyc = i;
        chk({name, "_done_stall"}, 64'(stall_req_o), 64'd0);
        break;
      end
      if (stall_req_o === 1'b1) stl++;
      @(negedge clk); #1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s_timeout actual=no_result expected=result", name);
    end else begin
      chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
      chk({name, "_stall_cycles"}, 64'(stl), 64'(exp_cyc));
    end
  endtask

  initial begin
    int p0;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    #1;
    chk("rst_hilo",  {hi_o, lo_o}, 64'd0);
    chk("rst_valid", 64'(res_valid_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 2);
    run_op("divu_100_7", DIVU, 32'd100,      32'd7,        64'h00000002_0000000E, 34);
    run_op("div_m7_2",  DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
    run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_op("divu_z",    DIVU,  32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, 34);
    run_op("div_z",     DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 34);
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2);
    run_op("mult_min",  MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 2);
    run_op("div_m100_7", DIV,  32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 34);

    // Flush a divide at cycle 10 after a known HI/LO.
    run_op("mult_known", MULT, 32'd3, 32'd4, 64'h00000000_0000000C, 2);
    @(negedge clk);
    start_i = 1'b1; op_i = DIV; a_i = 32'd1000; b_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    chk("flush_idle", 64'(busy_o), 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, 64'h00000000_0000000C);
    p0 = pulses;
    repeat (40) @(negedge clk);
    chk("flush_no_pulse", 64'(pulses), 64'(p0));
    run_op("multu_5_6", MULTU, 32'd5, 32'd6, 64'h00000000_0000001E, 2);
    start_i = 1'b0;

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start_i = 1'b1; op_i = DIV; a_i = 32'd77; b_i = 32'd5;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_hilo",  {hi_o, lo_o}, 64'd0);
    chk("arst_busy",  64'(busy_o), 64'd0);
    chk("arst_valid", 64'(res_valid_o), 64'd0);
    chk("arst_stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    run_op("b2b_first",  MULT, 32'd2,        32'd3,        64'h00000000_00000006, 2);
    run_op("b2b_second", MULT, 32'hFFFFFFFE, 32'hFFFFFFFE, 64'h00000000_00000004, 2);
    start_i = 1'b0;
    @(negedge clk); #1;
    chk("b2b_pulses", 64'(pulses), 64'(p0 + 2));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU issues from the instruction sitting in the ID/EX register and runs a 1-cycle multiply or a 32-iteration restoring divide. While busy it raises a stall request to the hazard unit, which drives `stallE` and the earlier stalls. On completion it presents the HI/LO pair for one release cycle, then returns to idle; the instruction advances and writes HI/LO.

## Interface
Parameters:
- `DIV_ITERS`, default 32, number of divide iterations (equals operand width; only 32 is supported).

Ports:
- `clk`  input  1  pipeline clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_i`  input  1  EX instruction is a mult/div op. Held high by the stalled pipeline until release.
- `op_i`  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only on accept.
- `a_i`  input  32  rs operand (dividend/multiplicand); sampled only on accept.
- `b_i`  input  32  rt operand (divisor/multiplier); sampled only on accept.
- `flush_i`  input  1  cancels any in-flight op (same source as `flushE`).
- `stall_req_o`  output  1  combinational stall request to hazard unit.
- `busy_o`  output  1  state is not IDLE.
- `res_valid_o`  output  1  one-cycle pulse; `hi_o`/`lo_o` hold a new result.
- `hi_o`  output  32  HI result (product high word / remainder).
- `lo_o`  output  32  LO result (product low word / quotient).

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: if `start_i & ~flush_i`:
  - latch op and operands.
  - For MUL, go to MUL.
  - For DIV/DIVU, load |a| (signed) or a into the working dividend, load |b| or b into the divisor, clear the 64-bit remainder/quotient register and the iteration counter, then go to DIV.
- MUL:
  - Compute the 64-bit product: signed if op=MULT, else unsigned.
  - Register `{hi_o, lo_o}`, then go to DONE.
- DIV: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract the 33-bit divisor.
  - If non-negative, keep the difference and set quo[0]=1.
  - Counter increments. After iteration `DIV_ITERS` (counter 31→wrap), go to FIX.
- FIX:
  - Signed: negate quotient if a[31]^b[31]; negate remainder if a[31].
  - Write `lo_o`=quotient and `hi_o`=remainder, then go to DONE.
- Divide by zero (b=0, either signedness): skip the iteration result. In FIX, `lo_o`=32'hFFFFFFFF and `hi_o`=a (the raw operand). Cycle count is unchanged.
- 0x80000000 / -1 (DIV): `lo_o`=32'h80000000, `hi_o`=0. Follows naturally from the magnitude path with 33-bit arithmetic.
- DONE:
  - `res_valid_o`=1, `stall_req_o`=0.
  - `start_i` is ignored (it still belongs to the same instruction).
  - Unconditionally go to IDLE.
- `flush_i`: in any state, next state is IDLE. `res_valid_o` does not fire. `hi_o`/`lo_o` keep their previous values. Flush has priority over start and over completion.
- `hi_o`/`lo_o` change only in MUL→DONE and FIX→DONE transitions; they hold otherwise.

## Timing
- Reset (async, immediate): state=IDLE, counter=0, `hi_o`=0, `lo_o`=0, `res_valid_o`=0, `busy_o`=0, `stall_req_o`=0 (start_i low).
- `stall_req_o` = `~flush_i & ((IDLE & start_i) | MUL | DIV | FIX)`.
- Mult: accept at cycle 0, MUL at 1, DONE at 2. Stall is high on cycles 0–1 (2 cycles). Result and pulse appear at cycle 2.
- Div: accept at 0, DIV at 1–32, FIX at 33, DONE at 34. Stall is high on cycles 0–33 (34 cycles). Result and pulse appear at cycle 34.
- Back-to-back ops: after DONE, a new `start_i` in the following IDLE cycle is accepted. This gives a minimum 1-cycle gap without stall between ops.
- Reset asserted mid-operation: immediate return to reset values. The in-flight result is discarded.

## Test plan
- MULT a=-3 (FFFFFFFD), b=7 → stall 2 cycles; at cycle 2 `hi_o`=FFFFFFFF, `lo_o`=FFFFFFEB, `res_valid_o` pulses once.
- DIVU a=100, b=7 → `stall_req_o` high for exactly 34 cycles; at cycle 34 `lo_o`=14, `hi_o`=2.
- DIV a=-7, b=2 → `lo_o`=FFFFFFFD, `hi_o`=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF → `lo_o`=80000000, `hi_o`=0.
- DIVU a=0x1234, b=0 → after 34 cycles `lo_o`=FFFFFFFF, `hi_o`=00001234.
- Run a mult to set known HI/LO, then start a DIV and assert `flush_i` at cycle 10:
  - IDLE next cycle; `stall_req_o` low during flush.
  - No `res_valid_o`; HI/LO unchanged.
  - A new MULTU 5×6 then yields `lo_o`=30, `hi_o`=0.
- Assert `rst` asynchronously mid-DIV (between clock edges) → outputs zero immediately. Then two back-to-back MULTs complete with one pulse each and no dropped start.
